// File: rtl/fight_pkg.sv
// Shared fight-logic types and constants: state encoding, counter widths and
// default frame data used by both the stun controller and the attack FSM.
package fight_pkg;
  localparam int FRAME_W  = 6;
  localparam int SPEED_W  = 4;
  localparam int HEALTH_W = 4;

  localparam int DEF_HITSTUN_FRAMES   = 20;
  localparam int DEF_BLOCKSTUN_FRAMES = 12;
  localparam int DEF_PUSH_FRAMES      = 8;
  localparam int DEF_PUSH_HIT_SPEED   = 3;
  localparam int DEF_PUSH_BLOCK_SPEED = 2;
  localparam int DEF_HEALTH_MAX       = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BLOCKSTUN = 2'd1,
    HITSTUN   = 2'd2,
    KO        = 2'd3
  } stun_state_t;

  typedef struct packed {
    logic hit;
    logic blk;
  } evt_t;

  function automatic logic [HEALTH_W-1:0] sat_dec(input logic [HEALTH_W-1:0] v);
    return (v == '0) ? v : v - HEALTH_W'(1);
  endfunction
endpackage

// File: rtl/frame_countdown.sv
// Loadable frame down-counter: load beats tick, decrement stops at zero.
module frame_countdown
  import fight_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [FRAME_W-1:0] load_val,
  input  logic               tick,
  output logic [FRAME_W-1:0] count,
  output logic               zero
);
  assign zero = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             count <= '0;
    else if (load)          count <= load_val;
    else if (tick && !zero) count <= count - FRAME_W'(1);
  end
endmodule

// File: rtl/stun_controller.sv
// Defender-side stun controller: one-shot hit/block events drive hit/blockstun,
// pushback, health and sticky KO; outputs lock the player's input FSMs.
module stun_controller
  import fight_pkg::*;
#(
  parameter int HITSTUN_FRAMES   = DEF_HITSTUN_FRAMES,
  parameter int BLOCKSTUN_FRAMES = DEF_BLOCKSTUN_FRAMES,
  parameter int PUSH_FRAMES      = DEF_PUSH_FRAMES,
  parameter int PUSH_HIT_SPEED   = DEF_PUSH_HIT_SPEED,
  parameter int PUSH_BLOCK_SPEED = DEF_PUSH_BLOCK_SPEED,
  parameter int HEALTH_MAX       = DEF_HEALTH_MAX
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_tick,
  input  logic                got_hit,
  input  logic                got_blocked,
  input  logic                round_reset,
  output logic                in_hitstun,
  output logic                in_blockstun,
  output logic                input_lock,
  output logic [FRAME_W-1:0]  stun_left,
  output logic                push_valid,
  output logic [SPEED_W-1:0]  push_speed,
  output logic [HEALTH_W-1:0] health,
  output logic                ko
);
  localparam int NUM_CNT  = 2;
  localparam int CNT_STUN = 0;
  localparam int CNT_PUSH = 1;

  stun_state_t state_q, state_d;
  logic got_hit_q, got_blocked_q;
  logic [HEALTH_W-1:0] health_q, health_dec;
  logic [SPEED_W-1:0]  speed_q;
  evt_t evt, acc;
  logic accepting, ko_hit, stun_state, stun_exit;

  logic [NUM_CNT-1:0]              cnt_load;
  logic [NUM_CNT-1:0][FRAME_W-1:0] cnt_val;
  logic [NUM_CNT-1:0][FRAME_W-1:0] cnt;
  logic [NUM_CNT-1:0]              cnt_zero;

  // Rising edges only; a simultaneous hit edge suppresses the block edge.
  always_comb begin
    evt.hit    = got_hit & ~got_hit_q;
    evt.blk    = got_blocked & ~got_blocked_q & ~evt.hit;
    accepting  = ~round_reset & ((state_q == IDLE) | (state_q == BLOCKSTUN));
    acc.hit    = accepting & evt.hit;
    acc.blk    = accepting & evt.blk;
    health_dec = sat_dec(health_q);
    ko_hit     = acc.hit & (health_dec == '0);
    stun_state = (state_q == BLOCKSTUN) | (state_q == HITSTUN);
    // A stun state with an empty counter also falls back to IDLE.
    stun_exit  = stun_state & (cnt_zero[CNT_STUN] |
                 (frame_tick & (cnt[CNT_STUN] == FRAME_W'(1))));
  end

  always_comb begin
    state_d = state_q;
    if (round_reset)  state_d = IDLE;
    else if (acc.hit) state_d = ko_hit ? KO : HITSTUN;
    else if (acc.blk) state_d = BLOCKSTUN;
    else if (stun_exit) state_d = IDLE;
  end

  always_comb begin
    cnt_load[CNT_STUN] = round_reset | acc.hit | acc.blk;
    cnt_load[CNT_PUSH] = round_reset | acc.hit | acc.blk;
    if (round_reset)  cnt_val[CNT_STUN] = '0;
    else if (acc.hit) cnt_val[CNT_STUN] = ko_hit ? '0 : FRAME_W'(HITSTUN_FRAMES);
    else              cnt_val[CNT_STUN] = FRAME_W'(BLOCKSTUN_FRAMES);
    cnt_val[CNT_PUSH] = round_reset ? '0 : FRAME_W'(PUSH_FRAMES);
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    frame_countdown u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load[g]),
      .load_val (cnt_val[g]),
      .tick     (frame_tick),
      .count    (cnt[g]),
      .zero     (cnt_zero[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      got_hit_q     <= 1'b0;
      got_blocked_q <= 1'b0;
      health_q      <= HEALTH_W'(HEALTH_MAX);
      speed_q       <= '0;
    end else begin
      state_q       <= state_d;
      got_hit_q     <= got_hit;
      got_blocked_q <= got_blocked;
      if (round_reset) begin
        health_q <= HEALTH_W'(HEALTH_MAX);
        speed_q  <= '0;
      end else if (acc.hit) begin
        health_q <= health_dec;
        speed_q  <= SPEED_W'(PUSH_HIT_SPEED);
      end else if (acc.blk) begin
        speed_q  <= SPEED_W'(PUSH_BLOCK_SPEED);
      end
    end
  end

  assign in_hitstun   = (state_q == HITSTUN);
  assign in_blockstun = (state_q == BLOCKSTUN);
  assign input_lock   = (state_q != IDLE);
  assign ko           = (state_q == KO);
  assign stun_left    = cnt[CNT_STUN];
  assign push_valid   = ~cnt_zero[CNT_PUSH];
  assign push_speed   = push_valid ? speed_q : '0;
  assign health       = health_q;
endmodule

// File: tb/tb_stun_controller.sv
// Directed bench for stun_controller: per-cycle vector table plus multi-cycle
// sequences for hold, reload, juggle, KO and async reset behaviour.
module tb_stun_controller;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0, got_hit = 1'b0, got_blocked = 1'b0, round_reset = 1'b0;
  logic       in_hitstun, in_blockstun, input_lock, push_valid, ko;
  logic [5:0] stun_left;
  logic [3:0] push_speed, health;

  int errors = 0;
  int checks = 0;

  stun_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .got_hit      (got_hit),
    .got_blocked  (got_blocked),
    .round_reset  (round_reset),
    .in_hitstun   (in_hitstun),
    .in_blockstun (in_blockstun),
    .input_lock   (input_lock),
    .stun_left    (stun_left),
    .push_valid   (push_valid),
    .push_speed   (push_speed),
    .health       (health),
    .ko           (ko)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic h, b, t, r;
    int lock, hs, bs, stun, pv, ps, hl, k;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int lock, input int hs, input int bs,
                         input int stun, input int pv, input int ps, input int hl, input int k);
    chk({name, " input_lock"}, int'(input_lock), lock);
    chk({name, " in_hitstun"}, int'(in_hitstun), hs);
    chk({name, " in_blockstun"}, int'(in_blockstun), bs);
    chk({name, " stun_left"}, int'(stun_left), stun);
    chk({name, " push_valid"}, int'(push_valid), pv);
    chk({name, " push_speed"}, int'(push_speed), ps);
    chk({name, " health"}, int'(health), hl);
    chk({name, " ko"}, int'(ko), k);
  endtask

  task automatic cyc(input logic h, input logic b, input logic t, input logic r);
    got_hit = h; got_blocked = b; frame_tick = t; round_reset = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{0,0,0,0, 0,0,0, 0,0,0,3,0};
    vecs[1]  = '{1,0,0,0, 1,1,0,20,1,3,2,0};
    vecs[2]  = '{1,0,1,0, 1,1,0,19,1,3,2,0};
    vecs[3]  = '{0,0,1,0, 1,1,0,18,1,3,2,0};
    vecs[4]  = '{1,0,0,0, 1,1,0,18,1,3,2,0};
    vecs[5]  = '{0,0,0,1, 0,0,0, 0,0,0,3,0};
    vecs[6]  = '{0,1,1,0, 1,0,1,12,1,2,3,0};
    vecs[7]  = '{0,0,1,0, 1,0,1,11,1,2,3,0};
    vecs[8]  = '{0,1,0,0, 1,0,1,12,1,2,3,0};
    vecs[9]  = '{1,0,0,0, 1,1,0,20,1,3,2,0};
    vecs[10] = '{0,0,0,1, 0,0,0, 0,0,0,3,0};
    vecs[11] = '{1,1,0,0, 1,1,0,20,1,3,2,0};
    vecs[12] = '{0,0,0,1, 0,0,0, 0,0,0,3,0};
    vecs[13] = '{1,0,0,1, 0,0,0, 0,0,0,3,0};
    vecs[14] = '{0,0,0,0, 0,0,0, 0,0,0,3,0};

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 3, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      cyc(vecs[i].h, vecs[i].b, vecs[i].t, vecs[i].r);
      chk_all($sformatf("vec%0d", i), vecs[i].lock, vecs[i].hs, vecs[i].bs,
              vecs[i].stun, vecs[i].pv, vecs[i].ps, vecs[i].hl, vecs[i].k);
    end

    // Held got_hit: one event only, 20-tick hitstun, 8-tick pushback.
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 100; i++) begin
      cyc(i < 40, 0, (i % 4) == 3, 0);
      if (i == 0) begin
        chk("hold hs", int'(in_hitstun), 1);
        chk("hold stun", int'(stun_left), 20);
        chk("hold health", int'(health), 2);
        chk("hold speed", int'(push_speed), 3);
      end
      if (i == 27) chk("hold pv7", int'(push_valid), 1);
      if (i == 31) begin
        chk("hold pv8", int'(push_valid), 0);
        chk("hold ps8", int'(push_speed), 0);
      end
      if (i == 75) begin
        chk("hold stun19", int'(stun_left), 1);
        chk("hold hs19", int'(in_hitstun), 1);
      end
      if (i == 79) begin
        chk("hold lock20", int'(input_lock), 0);
        chk("hold stun20", int'(stun_left), 0);
      end
    end
    chk("hold health end", int'(health), 2);

    // Block, second block after 5 ticks reloads: 17 ticks total.
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 80; i++) begin
      cyc(0, (i == 0) || (i == 20), (i % 4) == 3, 0);
      if (i == 19) chk("blk stun5", int'(stun_left), 7);
      if (i == 20) begin
        chk("blk reload", int'(stun_left), 12);
        chk("blk speed", int'(push_speed), 2);
        chk("blk bs", int'(in_blockstun), 1);
      end
      if (i == 63) chk("blk stun16", int'(stun_left), 1);
      if (i == 67) chk("blk lock17", int'(input_lock), 0);
    end
    chk("blk health", int'(health), 3);

    // Re-hit during hitstun is ignored.
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      cyc((i < 2) || (i >= 12 && i < 14), 0, (i % 4) == 3, 0);
      if (i == 12) begin
        chk("jug health", int'(health), 2);
        chk("jug stun", int'(stun_left), 17);
        chk("jug hs", int'(in_hitstun), 1);
      end
      if (i == 15) chk("jug stun dec", int'(stun_left), 16);
    end

    // Three hits to KO, KO sticky, round_reset recovers.
    cyc(0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0, 0);
      chk($sformatf("ko hit%0d health", k), int'(health), 2 - k);
      if (k < 2) begin
        chk($sformatf("ko hit%0d hs", k), int'(in_hitstun), 1);
        for (int j = 0; j < 20; j++) cyc(0, 0, 1, 0);
        chk($sformatf("ko hit%0d idle", k), int'(input_lock), 0);
      end
    end
    chk("ko flag", int'(ko), 1);
    chk("ko lock", int'(input_lock), 1);
    chk("ko stun", int'(stun_left), 0);
    chk("ko push", int'(push_valid), 1);
    for (int j = 0; j < 6; j++) cyc(j % 2 == 0, j % 2 == 1, 1, 0);
    chk("ko sticky", int'(ko), 1);
    chk("ko sticky health", int'(health), 0);
    chk("ko sticky stun", int'(stun_left), 0);
    cyc(0, 0, 0, 1);
    chk_all("ko rr", 0, 0, 0, 0, 0, 0, 3, 0);

    // Async reset mid-hitstun.
    cyc(1, 0, 0, 0);
    for (int j = 0; j < 10; j++) cyc(0, 0, 1, 0);
    chk("arst pre stun", int'(stun_left), 10);
    #2 rst_n = 1'b0;
    #1;
    chk_all("arst", 0, 0, 0, 0, 0, 0, 3, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);
    chk_all("arst post", 0, 0, 0, 0, 0, 0, 3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
